// File: rtl/stream_message_decoder_if.sv
// Line-stream bundle between the line source, the decoder and the text sink.
// The slave modport is the decoder's view; the master modport is the source/sink side.
interface stream_message_decoder_if #(
  parameter int MSG_WIDTH = 192
);
  logic                 in_valid;
  logic                 in_ready;
  logic [MSG_WIDTH-1:0] in_data;
  logic [7:0]           key;
  logic [1:0]           mode;
  logic                 out_valid;
  logic                 out_ready;
  logic [MSG_WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, key, mode, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, key, mode, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/stream_message_decoder.sv
// XOR line decoder, one byte per clock MSB-first; out_valid NB cycles after accept.
// The decoded line is held until out_ready; the next line may be accepted in the same cycle.
module stream_message_decoder #(
  parameter int          MSG_WIDTH = 192,
  parameter logic [7:0]  KEY_STEP  = 8'h01,
  parameter int          CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  stream_message_decoder_if.slave bus,
  output logic [CNT_WIDTH-1:0]  line_count,
  output logic                  busy
);
  localparam int NB = MSG_WIDTH / 8;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {IDLE, DECODE, HOLD} state_t;

  state_t               state_q, state_d;
  logic [MSG_WIDTH-1:0] data_q, data_d;
  logic [MSG_WIDTH-1:0] out_q, out_d;
  logic [7:0]           key_q, key_d;
  logic                 roll_q, roll_d;
  logic                 chain_q, chain_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [IW-1:0]        bpos;
  logic                 in_rdy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      out_q   <= '0;
      key_q   <= '0;
      roll_q  <= 1'b0;
      chain_q <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      out_q   <= out_d;
      key_q   <= key_d;
      roll_q  <= roll_d;
      chain_q <= chain_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    out_d   = out_q;
    key_d   = key_q;
    roll_d  = roll_q;
    chain_d = chain_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    in_rdy  = 1'b0;
    // Byte index counts from the MSB end so the first character decodes first.
    bpos    = IW'(NB - 1) - idx_q;

    case (state_q)
      IDLE: in_rdy = 1'b1;
      DECODE: begin
        out_d[{bpos, 3'b000} +: 8] = data_q[{bpos, 3'b000} +: 8] ^ key_q;
        if (roll_q) key_d = key_q + KEY_STEP;
        idx_d = idx_q + 1'b1;
        if (idx_q == IW'(NB - 1)) state_d = HOLD;
      end
      HOLD: begin
        in_rdy = bus.out_ready;
        if (bus.out_ready) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.in_valid && in_rdy) begin
      data_d  = bus.in_data;
      idx_d   = '0;
      state_d = DECODE;
      roll_d  = (bus.mode == 2'b01) || (bus.mode == 2'b10);
      // Continuous mode keeps rolling from the last line's final key once the chain is live.
      if (bus.mode == 2'b10) begin
        key_d   = chain_q ? key_q : bus.key;
        chain_d = 1'b1;
      end else begin
        key_d   = bus.key;
        chain_d = 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_data  = out_q;
  assign busy          = (state_q == DECODE);
  assign line_count    = cnt_q;
endmodule

// File: tb/tb_stream_message_decoder.sv
// Scoreboard bench for stream_message_decoder: expected lines are queued at accept and
// compared when the decoder hands them over; a second instance exercises a 2-bit counter.
module tb_stream_message_decoder;
  localparam int W  = 192;
  localparam int NB = W / 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stream_message_decoder_if #(.MSG_WIDTH(W)) bus ();
  stream_message_decoder_if #(.MSG_WIDTH(W)) bus2 ();
  logic [15:0] line_count;
  logic        busy;
  logic [1:0]  line_count2;
  logic        busy2;

  stream_message_decoder #(.MSG_WIDTH(W), .KEY_STEP(8'h01), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .bus(bus), .line_count(line_count), .busy(busy)
  );
  stream_message_decoder #(.MSG_WIDTH(W), .KEY_STEP(8'h01), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2), .line_count(line_count2), .busy(busy2)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cycle_cnt = 0;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  logic [W-1:0] exp_q[$];
  logic         tb_chain_valid = 1'b0;
  logic [7:0]   tb_chain_key   = 8'h00;
  int           tb_lines       = 0;

  function automatic logic [W-1:0] fill(input logic [7:0] b);
    logic [W-1:0] r;
    for (int i = 0; i < NB; i++) r[8*i +: 8] = b;
    return r;
  endfunction

  function automatic logic [W-1:0] rand_line();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic push_expected(input logic [W-1:0] d, input logic [7:0] k, input logic [1:0] m);
    logic [W-1:0] e;
    logic [7:0]   kk;
    bit           roll;
    roll = (m == 2'b01) || (m == 2'b10);
    if (m == 2'b10) begin
      kk = tb_chain_valid ? tb_chain_key : k;
      tb_chain_valid = 1'b1;
    end else begin
      kk = k;
      tb_chain_valid = 1'b0;
    end
    for (int i = 0; i < NB; i++) begin
      e[W-1-8*i -: 8] = d[W-1-8*i -: 8] ^ kk;
      if (roll) kk = kk + 8'h01;
    end
    tb_chain_key = kk;
    exp_q.push_back(e);
  endtask

  task automatic send_line(input logic [W-1:0] d, input logic [7:0] k, input logic [1:0] m,
                           output int acc_cyc, output bit to);
    to = 1'b1;
    acc_cyc = 0;
    @(negedge clk);
    bus.in_data  = d;
    bus.key      = k;
    bus.mode     = m;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      #1;
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        acc_cyc = cycle_cnt;
        to = 1'b0;
        push_expected(d, k, m);
        bus.in_valid = 1'b0;
        bus.in_data  = rand_line();
        bus.key      = 8'($urandom);
        bus.mode     = 2'($urandom);
        break;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc, output bit to);
    to = 1'b1;
    cyc = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        cyc = cycle_cnt;
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic take_line(output logic [W-1:0] d);
    d = bus.out_data;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    tb_lines++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_tests++; if (bus.out_data !== '0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", bus.out_data); end
    n_tests++; if (line_count !== 16'd0) begin n_fail++; $display("FAIL reset_line_count got %0d want 0", line_count); end
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++; if (line_count2 !== 2'd0) begin n_fail++; $display("FAIL reset_line_count2 got %0d want 0", line_count2); end
  endtask

  task automatic test_fixed_key();
    int acc, cyc;
    bit to, tv;
    logic [W-1:0] got, e;
    send_line(fill(8'h68), 8'h20, 2'b00, acc, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL fixed_accept got timeout want accept"); end
    wait_valid(cyc, tv);
    n_tests++; if (tv) begin n_fail++; $display("FAIL fixed_out_valid got timeout want valid"); end
    if (!to && !tv) begin
      n_tests++; if (cyc - acc !== 24) begin n_fail++; $display("FAIL fixed_latency got %0d want 24", cyc - acc); end
      e = exp_q.pop_front();
      take_line(got);
      n_tests++; if (got !== e) begin n_fail++; $display("FAIL fixed_data_sb got %h want %h", got, e); end
      n_tests++; if (got !== fill(8'h48)) begin n_fail++; $display("FAIL fixed_data got %h want %h", got, fill(8'h48)); end
      n_tests++; if (line_count !== 16'(tb_lines)) begin n_fail++; $display("FAIL fixed_line_count got %0d want %0d", line_count, tb_lines); end
    end
  endtask

  task automatic test_rolling_line();
    int acc, cyc;
    bit to, tv;
    logic [W-1:0] got, e, c, first;
    first = '0;
    for (int i = 0; i < NB; i++) c[W-1-8*i -: 8] = 8'h41 ^ 8'(i);
    for (int rep = 0; rep < 2; rep++) begin
      send_line(fill(8'h41), 8'h00, 2'b01, acc, to);
      wait_valid(cyc, tv);
      n_tests++; if (to || tv) begin n_fail++; $display("FAIL rolling_handshake got timeout want line %0d", rep); end
      if (!to && !tv) begin
        e = exp_q.pop_front();
        take_line(got);
        n_tests++; if (got !== e) begin n_fail++; $display("FAIL rolling_data_sb got %h want %h", got, e); end
        n_tests++; if (got !== c) begin n_fail++; $display("FAIL rolling_data got %h want %h", got, c); end
        if (rep == 0) first = got;
        else begin
          n_tests++; if (got !== first) begin n_fail++; $display("FAIL rolling_repeat got %h want %h", got, first); end
        end
      end
    end
  endtask

  task automatic test_continuous();
    int acc, cyc;
    bit to, tv;
    logic [W-1:0] got, e, c;
    logic [7:0] kport [2];
    kport[0] = 8'h00;
    kport[1] = 8'hA5;
    for (int ln = 0; ln < 2; ln++) begin
      for (int i = 0; i < NB; i++) c[W-1-8*i -: 8] = 8'(ln * NB + i);
      send_line('0, kport[ln], 2'b10, acc, to);
      wait_valid(cyc, tv);
      n_tests++; if (to || tv) begin n_fail++; $display("FAIL continuous_handshake got timeout want line %0d", ln); end
      if (!to && !tv) begin
        e = exp_q.pop_front();
        take_line(got);
        n_tests++; if (got !== e) begin n_fail++; $display("FAIL continuous_data_sb got %h want %h", got, e); end
        n_tests++; if (got !== c) begin n_fail++; $display("FAIL continuous_data got %h want %h", got, c); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc, cyc;
    bit to, tv;
    logic [W-1:0] d1, d2, hold_dat, got, e;
    d1 = rand_line();
    d2 = rand_line();
    send_line(d1, 8'h5A, 2'b00, acc, to);
    wait_valid(cyc, tv);
    n_tests++; if (to || tv) begin n_fail++; $display("FAIL b2b_first got timeout want valid"); end
    if (!to && !tv) begin
      hold_dat = bus.out_data;
      bus.in_data  = d2;
      bus.key      = 8'h3C;
      bus.mode     = 2'b01;
      bus.in_valid = 1'b1;
      for (int n = 0; n < 10; n++) begin
        @(negedge clk);
        n_tests++; if (bus.out_data !== hold_dat) begin n_fail++; $display("FAIL hold_stable got %h want %h", bus.out_data, hold_dat); end
        n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready got %b want 0", bus.in_ready); end
      end
      bus.out_ready = 1'b1;
      #1;
      n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready got %b want 1", bus.in_ready); end
      @(posedge clk);
      push_expected(d2, 8'h3C, 2'b01);
      #1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      tb_lines++;
      @(negedge clk);
      n_tests++; if (line_count !== 16'(tb_lines)) begin n_fail++; $display("FAIL b2b_line_count got %0d want %0d", line_count, tb_lines); end
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy got %b want 1", busy); end
      n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_out_valid got %b want 0", bus.out_valid); end
      e = exp_q.pop_front();
      n_tests++; if (hold_dat !== e) begin n_fail++; $display("FAIL b2b_first_data got %h want %h", hold_dat, e); end
      wait_valid(cyc, tv);
      n_tests++; if (tv) begin n_fail++; $display("FAIL b2b_second got timeout want valid"); end
      if (!tv) begin
        e = exp_q.pop_front();
        take_line(got);
        n_tests++; if (got !== e) begin n_fail++; $display("FAIL b2b_second_data got %h want %h", got, e); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int acc, cyc;
    bit to, tv;
    logic [W-1:0] d, got, e;
    send_line(rand_line(), 8'h10, 2'b10, acc, to);
    wait_valid(cyc, tv);
    if (!to && !tv) begin
      e = exp_q.pop_front();
      take_line(got);
      n_tests++; if (got !== e) begin n_fail++; $display("FAIL chain_prime_data got %h want %h", got, e); end
    end else begin
      n_tests++; n_fail++; $display("FAIL chain_prime got timeout want line");
    end
    send_line(rand_line(), 8'h77, 2'b10, acc, to);
    repeat (10) @(negedge clk);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midline_busy got %b want 1", busy); end
    reset = 1'b1;
    #1;
    n_tests++; if (line_count !== 16'd0) begin n_fail++; $display("FAIL async_reset_count got %0d want 0", line_count); end
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    tb_chain_valid = 1'b0;
    tb_lines = 0;
    #1;
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b want 0", bus.out_valid); end
    n_tests++; if (line_count !== 16'd0) begin n_fail++; $display("FAIL rst_line_count got %0d want 0", line_count); end
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b want 1", bus.in_ready); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
    d = rand_line();
    send_line(d, 8'h33, 2'b10, acc, to);
    wait_valid(cyc, tv);
    n_tests++; if (to || tv) begin n_fail++; $display("FAIL post_reset got timeout want line"); end
    if (!to && !tv) begin
      e = exp_q.pop_front();
      take_line(got);
      n_tests++; if (got !== e) begin n_fail++; $display("FAIL post_reset_data got %h want %h", got, e); end
      n_tests++; if (got[W-1 -: 8] !== (d[W-1 -: 8] ^ 8'h33)) begin n_fail++; $display("FAIL post_reset_key got %h want %h", got[W-1 -: 8], d[W-1 -: 8] ^ 8'h33); end
      n_tests++; if (line_count !== 16'd1) begin n_fail++; $display("FAIL post_reset_count got %0d want 1", line_count); end
    end
  endtask

  task automatic test_count_wrap();
    logic [W-1:0] d, got;
    bit ok;
    for (int i = 0; i < 5; i++) begin
      d = rand_line();
      @(negedge clk);
      bus2.in_data  = d;
      bus2.key      = 8'h00;
      bus2.mode     = 2'b00;
      bus2.in_valid = 1'b1;
      ok = 1'b0;
      for (int n = 0; n < 100; n++) begin
        #1;
        if (bus2.in_ready) begin ok = 1'b1; @(posedge clk); #1; break; end
        @(negedge clk);
      end
      bus2.in_valid = 1'b0;
      if (ok) begin
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
          @(negedge clk);
          if (bus2.out_valid) begin ok = 1'b1; break; end
        end
      end
      n_tests++; if (!ok) begin n_fail++; $display("FAIL wrap_handshake got timeout want line %0d", i); end
      if (ok) begin
        got = bus2.out_data;
        bus2.out_ready = 1'b1;
        @(negedge clk);
        bus2.out_ready = 1'b0;
        n_tests++; if (got !== d) begin n_fail++; $display("FAIL wrap_data got %h want %h", got, d); end
        n_tests++; if (line_count2 !== 2'((i + 1) % 4)) begin n_fail++; $display("FAIL wrap_count got %0d want %0d", line_count2, (i + 1) % 4); end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.key = '0; bus.mode = '0; bus.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.key = '0; bus2.mode = '0; bus2.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_fixed_key();
    test_rolling_line();
    test_continuous();
    test_back_to_back();
    test_reset_mid();
    test_count_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
